// File: rtl/jtag_host.sv
// JTAG host: drives TMS/TDI to a target TAP, mirrors its state, and runs
// IR/DR scans of up to DW bits, capturing TDO LSB-first into dout.
module jtag_host #(
   parameter int unsigned DW = 32,
   parameter int unsigned LW = 6
) (
   input  logic          TCK,
   input  logic          TRST,
   input  logic          start,
   input  logic          scan_ir,
   input  logic [LW-1:0] len,
   input  logic [DW-1:0] din,
   input  logic          TDO,
   output logic          TMS,
   output logic          TDI,
   output logic          busy,
   output logic          done,
   output logic [DW-1:0] dout,
   output logic [3:0]    state_obs
);

   localparam int unsigned CW        = 3;
   localparam int unsigned INIT_ONES = 5;

   typedef enum logic [3:0] {
      TLR      = 4'd0,  RTI      = 4'd1,  SEL_DR   = 4'd2,  CAP_DR   = 4'd3,
      SHIFT_DR = 4'd4,  EXIT1_DR = 4'd5,  PAUSE_DR = 4'd6,  EXIT2_DR = 4'd7,
      UPD_DR   = 4'd8,  SEL_IR   = 4'd9,  CAP_IR   = 4'd10, SHIFT_IR = 4'd11,
      EXIT1_IR = 4'd12, PAUSE_IR = 4'd13, EXIT2_IR = 4'd14, UPD_IR   = 4'd15
   } tap_t;

   typedef enum logic [1:0] {M_INIT, M_RECOVER, M_IDLE, M_SCAN} mode_t;

   tap_t          tap, tap_n;
   mode_t         mode, mode_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [LW-1:0] idx, idx_n, len_q, len_n, len_c;
   logic          ir_q, ir_n;
   logic [DW-1:0] data_q, data_n, dout_n;
   logic          tms_n, tdi_n, busy_n, done_n;
   logic          in_shift, recover;

   // IEEE 1149.1 TAP transition rule
   function automatic tap_t tap_step(input tap_t s, input logic m);
      tap_step = s;
      case (s)
         TLR:      tap_step = m ? TLR      : RTI;
         RTI:      tap_step = m ? SEL_DR   : RTI;
         SEL_DR:   tap_step = m ? SEL_IR   : CAP_DR;
         CAP_DR:   tap_step = m ? EXIT1_DR : SHIFT_DR;
         SHIFT_DR: tap_step = m ? EXIT1_DR : SHIFT_DR;
         EXIT1_DR: tap_step = m ? UPD_DR   : PAUSE_DR;
         PAUSE_DR: tap_step = m ? EXIT2_DR : PAUSE_DR;
         EXIT2_DR: tap_step = m ? UPD_DR   : SHIFT_DR;
         UPD_DR:   tap_step = m ? SEL_DR   : RTI;
         SEL_IR:   tap_step = m ? TLR      : CAP_IR;
         CAP_IR:   tap_step = m ? EXIT1_IR : SHIFT_IR;
         SHIFT_IR: tap_step = m ? EXIT1_IR : SHIFT_IR;
         EXIT1_IR: tap_step = m ? UPD_IR   : PAUSE_IR;
         PAUSE_IR: tap_step = m ? EXIT2_IR : PAUSE_IR;
         EXIT2_IR: tap_step = m ? UPD_IR   : SHIFT_IR;
         UPD_IR:   tap_step = m ? SEL_DR   : RTI;
      endcase
   endfunction

   always_ff @(posedge TCK) begin
      if (TRST) begin
         tap    <= TLR;
         mode   <= M_INIT;
         cnt    <= '0;
         idx    <= '0;
         len_q  <= '0;
         ir_q   <= 1'b0;
         data_q <= '0;
         dout   <= '0;
         TMS    <= 1'b1;
         TDI    <= 1'b0;
         busy   <= 1'b1;
         done   <= 1'b0;
      end else begin
         tap    <= tap_n;
         mode   <= mode_n;
         cnt    <= cnt_n;
         idx    <= idx_n;
         len_q  <= len_n;
         ir_q   <= ir_n;
         data_q <= data_n;
         dout   <= dout_n;
         TMS    <= tms_n;
         TDI    <= tdi_n;
         busy   <= busy_n;
         done   <= done_n;
      end
   end

   // TMS/TDI for the coming cycle are chosen from the state the mirror is entering
   always_comb begin
      tap_n    = tap_step(tap, TMS);
      mode_n   = mode;
      cnt_n    = cnt;
      idx_n    = idx;
      len_n    = len_q;
      ir_n     = ir_q;
      data_n   = data_q;
      dout_n   = dout;
      tms_n    = TMS;
      tdi_n    = 1'b0;
      busy_n   = busy;
      done_n   = 1'b0;
      recover  = 1'b0;
      in_shift = (tap == SHIFT_DR) || (tap == SHIFT_IR);
      len_c    = (len == '0) ? LW'(1) : ((len > LW'(DW)) ? LW'(DW) : len);

      unique case (mode)
         M_INIT: begin
            cnt_n = cnt + CW'(1);
            tms_n = (cnt_n < CW'(INIT_ONES));
            if (cnt == CW'(INIT_ONES)) begin
               mode_n = M_IDLE;
               busy_n = 1'b0;
               cnt_n  = '0;
            end
         end
         M_RECOVER: begin
            recover = 1'b1;
         end
         M_IDLE: begin
            tms_n = 1'b0;
            if (tap_n != RTI) begin
               recover = 1'b1;
            end else if (start) begin
               mode_n = M_SCAN;
               busy_n = 1'b1;
               dout_n = '0;
               data_n = din;
               len_n  = len_c;
               ir_n   = scan_ir;
               idx_n  = '0;
               tms_n  = 1'b1;
            end
         end
         M_SCAN: begin
            if (in_shift) begin
               dout_n = dout | (DW'(TDO) << idx);
               idx_n  = idx + LW'(1);
            end
            case (tap_n)
               RTI: begin
                  mode_n = M_IDLE;
                  busy_n = 1'b0;
                  done_n = 1'b1;
                  tms_n  = 1'b0;
               end
               SEL_DR:                                tms_n = ir_q;
               SEL_IR, CAP_DR, CAP_IR, UPD_DR, UPD_IR: tms_n = 1'b0;
               EXIT1_DR, EXIT1_IR:                    tms_n = 1'b1;
               SHIFT_DR, SHIFT_IR: begin
                  tms_n = (idx_n == len_q - LW'(1));
                  tdi_n = |(data_q & (DW'(1) << idx_n));
               end
               default: recover = 1'b1;
            endcase
         end
      endcase

      // Off-path mirror: hold TMS high until Test_Logic_Reset, then re-run init
      if (recover) begin
         tms_n  = 1'b1;
         tdi_n  = 1'b0;
         busy_n = 1'b1;
         done_n = 1'b0;
         cnt_n  = '0;
         mode_n = (tap_n == TLR) ? M_INIT : M_RECOVER;
      end
   end

   assign state_obs = 4'(tap);

endmodule

// File: doc/jtag_host.md
JTAG_HOST -- requirements
Module: jtag_host

Interface
REQ-001 Parameter DW, default 32: maximum scan length in bits.
REQ-002 Parameter LW, default 6: width of len, equal to $clog2(DW)+1.
REQ-003 The block SHALL have one clock; reset is synchronous and active-high.
REQ-004 TCK  input  1  scan clock; all state changes occur on its rising edge.
REQ-005 TRST  input  1  synchronous active-high reset.
REQ-006 start  input  1  scan request; sampled only when busy=0.
REQ-007 scan_ir  input  1  selects scan type: 1 = IR scan, 0 = DR scan; latched with start.
REQ-008 len  input  LW  scan length in bits; latched with start.
REQ-009 din  input  DW  shift-in data, LSB first; latched with start.
REQ-010 TDO  input  1  serial data returned by the target.
REQ-011 TMS  output  1  registered mode select driven to the target.
REQ-012 TDI  output  1  registered serial data driven to the target.
REQ-013 busy  output  1  high while the init sequence or a scan is in progress.
REQ-014 done  output  1  one-cycle pulse when a scan completes.
REQ-015 dout  output  DW  captured TDO bits; bit i holds the i-th sample.
REQ-016 state_obs  output  4  mirrored target TAP state, using the project TAP 4-bit encoding (Test_logic_Reset=0000 through Update_IR=1111).

Function
REQ-017 The mirror SHALL update every TCK edge by the IEEE 1149.1 transition rule, using the TMS value presented during the ending cycle; state_obs SHALL equal the state of a target clocked by the same TCK.
REQ-018 Init: after TRST deasserts, TMS SHALL be 1 for 5 cycles, then 0 for 1 cycle; the mirror then enters Run_Test_Idle (0001) and busy falls on that edge.
REQ-019 Idle: while the mirror is Run_Test_Idle and busy=0, TMS=0, TDI=0, and done=0.
REQ-020 start SHALL be accepted only when busy=0; busy rises on the accepting edge; start while busy=1 is ignored.
REQ-021 len=0 SHALL be treated as 1, and len>DW SHALL be clamped to DW.
REQ-022 DR scan TMS sequence: 1,0,0, then (len-1) zeros, then 1,1,0 (Select_DR, Capture_DR, Shift_DR, Exit1_DR, Update_DR, Run_Test_Idle).
REQ-023 IR scan TMS sequence: 1,1,0,0, then (len-1) zeros, then 1,1,0 (the path passes through Select_IR_Scan).
REQ-024 During the i-th cycle with the mirror in Shift_DR or Shift_IR (i=0..len-1), TDI SHALL equal latched din[i]; TMS SHALL be 1 only when i=len-1.
REQ-025 At each of those len edges, the block SHALL sample TDO into dout[i]; dout bits at len and above SHALL be 0.
REQ-026 dout SHALL be cleared on the accepting edge, and SHALL hold its value from done until the next accepted start.
REQ-027 Latency: done pulses, and busy falls, on the edge where the mirror re-enters Run_Test_Idle, i.e. len+5 edges (DR) or len+6 edges (IR) after the accepting edge.
REQ-028 The block SHALL never use Pause_xR or Exit2_xR; if the mirror reaches any state off the scan path, it SHALL drive TMS=1 until Test_logic_Reset, then run the REQ-018 sequence.
REQ-029 start asserted on the same edge that busy falls SHALL be ignored; acceptance is possible from the next edge.

Reset
REQ-030 While TRST=1: TMS=1, TDI=0, busy=1, done=0, dout=0, state_obs=0000.
REQ-031 TRST mid-scan SHALL abort the scan with no done pulse; the REQ-018 init sequence follows.

Verification
REQ-032 Reset: TRST for 1 cycle -> TMS=1 for 5 cycles then 0, state_obs 0000 then 0001, busy falls after 6 cycles.
REQ-033 IR scan, len=4, din=0xA -> TMS 1,1,0,0,0,0,0,1,1,0; TDI in Shift 0,1,0,1; done on the 10th edge.
REQ-034 DR scan, len=8, TDO tied to 1 -> dout=0x000000FF; done on the 13th edge; state_obs path 0010,0011,0100x8,0101,1000,0001.
REQ-035 TDO looped back from TDI, DR scan, len=32, din=0xDEADBEEF -> dout=0xDEADBEEF; state_obs matches a paired project TAP controller every cycle.
REQ-036 start pulsed while busy=1 -> ignored, no extra done; len=0 -> 1-bit scan, done after 6 edges (DR).
REQ-037 TRST asserted during the 3rd Shift cycle -> no done pulse, dout=0, state_obs=0000, then the init sequence.
